// File: rtl/tl_ul_mem_responder_if.sv
// TileLink-UL A/D channel bundle for the single-outstanding memory responder.
// Field widths come from the TL_* macros; defaults apply when the build does not set them.
`ifndef TL_SIZE_BITS
`define TL_SIZE_BITS 3
`endif
`ifndef TL_SOURCE_BITS
`define TL_SOURCE_BITS 8
`endif
`ifndef TL_ADDR_BITS
`define TL_ADDR_BITS 32
`endif
`ifndef TL_DATA_BYTES
`define TL_DATA_BYTES 8
`endif

interface tl_ul_mem_responder_if;
    logic                           a_valid;
    logic                           a_ready;
    logic [2:0]                     a_opcode;
    logic [2:0]                     a_param;
    logic [`TL_SIZE_BITS-1:0]       a_size;
    logic [`TL_SOURCE_BITS-1:0]     a_source;
    logic [`TL_ADDR_BITS-1:0]       a_address;
    logic [`TL_DATA_BYTES-1:0]      a_mask;
    logic [`TL_DATA_BYTES*8-1:0]    a_data;

    logic                           d_valid;
    logic                           d_ready;
    logic [2:0]                     d_opcode;
    logic [1:0]                     d_param;
    logic [`TL_SIZE_BITS-1:0]       d_size;
    logic [`TL_SOURCE_BITS-1:0]     d_source;
    logic                           d_sink;
    logic                           d_denied;
    logic [`TL_DATA_BYTES*8-1:0]    d_data;
    logic                           d_corrupt;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
        input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data,
               d_corrupt
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
        output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data,
               d_corrupt
    );
endinterface

// File: rtl/tl_ul_mem_responder.sv
// TileLink-UL memory responder: one outstanding request, IDLE -> ACCESS -> RESP,
// 64-bit word storage with byte-lane writes and a saturating denied-request counter.
`ifndef TL_SIZE_BITS
`define TL_SIZE_BITS 3
`endif
`ifndef TL_SOURCE_BITS
`define TL_SOURCE_BITS 8
`endif
`ifndef TL_ADDR_BITS
`define TL_ADDR_BITS 32
`endif
`ifndef TL_DATA_BYTES
`define TL_DATA_BYTES 8
`endif

module tl_ul_mem_responder #(
    parameter int unsigned             MEM_WORDS = 4096,
    parameter logic [`TL_ADDR_BITS-1:0] BASE_ADDR = 32'h0
) (
    input  logic                        clk,
    input  logic                        rst,
    tl_ul_mem_responder_if.slave        bus,
    output logic                        busy,
    output logic [7:0]                  denied_count
);

    localparam int unsigned IdxW  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned DataW = `TL_DATA_BYTES * 8;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StResp   = 2'd2;

    localparam logic [2:0] OpPutFull    = 3'd0;
    localparam logic [2:0] OpPutPartial = 3'd1;
    localparam logic [2:0] OpGet        = 3'd4;
    localparam logic [2:0] OpAccessAck     = 3'd0;
    localparam logic [2:0] OpAccessAckData = 3'd1;

    logic [1:0]                     state_q, state_d;
    logic [2:0]                     op_q;
    logic [`TL_SIZE_BITS-1:0]       size_q;
    logic [`TL_SOURCE_BITS-1:0]     src_q;
    logic [`TL_ADDR_BITS-1:0]       addr_q;
    logic [`TL_DATA_BYTES-1:0]      mask_q;
    logic [DataW-1:0]               data_q;

    logic [2:0]                     d_opcode_q;
    logic [`TL_SIZE_BITS-1:0]       d_size_q;
    logic [`TL_SOURCE_BITS-1:0]     d_source_q;
    logic                           d_denied_q;
    logic [DataW-1:0]               d_data_q;
    logic                           d_corrupt_q;
    logic [7:0]                     denied_count_q;

    logic [DataW-1:0]               mem [MEM_WORDS];

    logic [`TL_ADDR_BITS-1:0]       offset;
    logic [IdxW-1:0]                idx;
    logic                           is_get, bad_op, bad_size, misalign, below, oob, denied;
    logic                           unused_param;

    assign unused_param = ^bus.a_param;

    // Request decode works on the captured A fields, valid throughout ACCESS.
    assign offset   = addr_q - BASE_ADDR;
    assign idx      = offset[3 +: IdxW];
    assign is_get   = (op_q == OpGet);
    assign bad_op   = !(op_q == OpPutFull || op_q == OpPutPartial || op_q == OpGet);
    assign bad_size = (size_q > `TL_SIZE_BITS'(3));
    assign below    = (addr_q < BASE_ADDR);
    assign oob      = ({3'b000, offset[`TL_ADDR_BITS-1:3]} >= `TL_ADDR_BITS'(MEM_WORDS));

    always_comb begin
        misalign = 1'b0;
        case (size_q)
            `TL_SIZE_BITS'(1): misalign = addr_q[0];
            `TL_SIZE_BITS'(2): misalign = |addr_q[1:0];
            `TL_SIZE_BITS'(3): misalign = |addr_q[2:0];
            default:           misalign = 1'b0;
        endcase
    end

    assign denied = bad_op | bad_size | misalign | below | oob;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (bus.a_valid) state_d = StAccess;
            StAccess: state_d = StResp;
            StResp:   if (bus.d_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            op_q           <= '0;
            size_q         <= '0;
            src_q          <= '0;
            addr_q         <= '0;
            mask_q         <= '0;
            data_q         <= '0;
            d_opcode_q     <= '0;
            d_size_q       <= '0;
            d_source_q     <= '0;
            d_denied_q     <= 1'b0;
            d_data_q       <= '0;
            d_corrupt_q    <= 1'b0;
            denied_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && bus.a_valid) begin
                op_q   <= bus.a_opcode;
                size_q <= bus.a_size;
                src_q  <= bus.a_source;
                addr_q <= bus.a_address;
                mask_q <= bus.a_mask;
                data_q <= bus.a_data;
            end
            if (state_q == StAccess) begin
                d_opcode_q  <= is_get ? OpAccessAckData : OpAccessAck;
                d_size_q    <= size_q;
                d_source_q  <= src_q;
                d_denied_q  <= denied;
                d_data_q    <= (is_get && !denied) ? mem[idx] : '0;
                d_corrupt_q <= is_get & denied;
                if (denied && denied_count_q != 8'hFF) begin
                    denied_count_q <= denied_count_q + 8'd1;
                end
            end
        end
    end

    // Storage is never reset; an async reset in ACCESS leaves state_q != StAccess at the edge.
    always_ff @(posedge clk) begin
        if (state_q == StAccess && !denied && !is_get) begin
            for (int b = 0; b < `TL_DATA_BYTES; b++) begin
                if (mask_q[b]) mem[idx][8*b +: 8] <= data_q[8*b +: 8];
            end
        end
    end

    assign bus.a_ready  = (state_q == StIdle) & ~rst;
    assign bus.d_valid  = (state_q == StResp);
    assign bus.d_opcode = d_opcode_q;
    assign bus.d_param  = 2'b00;
    assign bus.d_size   = d_size_q;
    assign bus.d_source = d_source_q;
    assign bus.d_sink   = 1'b0;
    assign bus.d_denied = d_denied_q;
    assign bus.d_data   = d_data_q;
    assign bus.d_corrupt = d_corrupt_q;
    assign busy         = (state_q != StIdle);
    assign denied_count = denied_count_q;

endmodule

// File: tb/tb_tl_ul_mem_responder.sv
// Bench for tl_ul_mem_responder: directed scenarios then randomized traffic, checked
// against a word-map model that applies the access/deny rules directly.
`ifndef TL_SIZE_BITS
`define TL_SIZE_BITS 3
`endif
`ifndef TL_SOURCE_BITS
`define TL_SOURCE_BITS 8
`endif
`ifndef TL_ADDR_BITS
`define TL_ADDR_BITS 32
`endif
`ifndef TL_DATA_BYTES
`define TL_DATA_BYTES 8
`endif

module tb_tl_ul_mem_responder;
    localparam int unsigned MemWords = 4096;
    localparam logic [31:0] Base     = 32'h0;

    logic       clk;
    logic       rst;
    logic       busy;
    logic [7:0] denied_count;

    tl_ul_mem_responder_if bus ();

    tl_ul_mem_responder #(
        .MEM_WORDS (MemWords),
        .BASE_ADDR (Base)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .busy         (busy),
        .denied_count (denied_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [63:0] mem_m [int];
    int          dc_m = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_denied(input logic [2:0] op, input logic [2:0] size,
                                    input logic [31:0] addr);
        longint unsigned a = longint'(addr);
        if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) return 1'b1;
        if (size > 3) return 1'b1;
        if ((a % (64'd1 << size)) != 0) return 1'b1;
        if (a < longint'(Base)) return 1'b1;
        if (((a - longint'(Base)) / 8) >= MemWords) return 1'b1;
        return 1'b0;
    endfunction

    task automatic txn(input logic [2:0] op, input logic [2:0] size, input logic [7:0] src,
                       input logic [31:0] addr, input logic [7:0] mask, input logic [63:0] data,
                       input int hold, output logic [63:0] rdata);
        bit          den;
        int          widx;
        logic [63:0] exp_data;
        den  = m_denied(op, size, addr);
        widx = int'((addr - Base) >> 3);
        exp_data = (op == 3'd4 && !den) ? mem_m[widx] : 64'h0;

        @(negedge clk);
        bus.a_valid = 1'b1; bus.a_opcode = op; bus.a_param = 3'($urandom_range(7));
        bus.a_size = size; bus.a_source = src; bus.a_address = addr;
        bus.a_mask = mask; bus.a_data = data;
        check("a_ready_idle", 64'(bus.a_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.a_valid = 1'b0; bus.a_address = $urandom; bus.a_opcode = 3'($urandom_range(7));
        check("access_d_valid", 64'(bus.d_valid), 64'd0);
        check("access_busy", 64'(busy), 64'd1);
        check("access_a_ready", 64'(bus.a_ready), 64'd0);

        if (den) dc_m = (dc_m < 255) ? dc_m + 1 : 255;
        if (!den && op != 3'd4) begin
            logic [63:0] w;
            w = mem_m.exists(widx) ? mem_m[widx] : 64'h0;
            for (int b = 0; b < 8; b++) if (mask[b]) w[8*b +: 8] = data[8*b +: 8];
            mem_m[widx] = w;
        end

        for (int c = 0; c <= hold; c++) begin
            @(posedge clk);
            #1;
            check("resp_d_valid", 64'(bus.d_valid), 64'd1);
            check("resp_a_ready", 64'(bus.a_ready), 64'd0);
            check("d_opcode", 64'(bus.d_opcode), (op == 3'd4) ? 64'd1 : 64'd0);
            check("d_param", 64'(bus.d_param), 64'd0);
            check("d_sink", 64'(bus.d_sink), 64'd0);
            check("d_size", 64'(bus.d_size), 64'(size));
            check("d_source", 64'(bus.d_source), 64'(src));
            check("d_denied", 64'(bus.d_denied), 64'(den));
            check("d_corrupt", 64'(bus.d_corrupt), 64'(den && op == 3'd4));
            check("d_data", bus.d_data, exp_data);
            check("denied_count", 64'(denied_count), 64'(dc_m));
        end
        rdata = bus.d_data;
        @(negedge clk);
        bus.d_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.d_ready = 1'b0;
        check("after_fire_d_valid", 64'(bus.d_valid), 64'd0);
        check("after_fire_a_ready", 64'(bus.a_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        logic [31:0] addr;
        logic [2:0]  op, size;
        int          k;

        rst = 1'b1;
        bus.a_valid = 1'b0; bus.a_opcode = '0; bus.a_param = '0; bus.a_size = '0;
        bus.a_source = '0; bus.a_address = '0; bus.a_mask = '0; bus.a_data = '0;
        bus.d_ready = 1'b0;
        #1;
        check("rst_a_ready", 64'(bus.a_ready), 64'd0);
        check("rst_d_valid", 64'(bus.d_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_denied_count", 64'(denied_count), 64'd0);
        check("rst_d_data", bus.d_data, 64'd0);
        check("rst_d_source", 64'(bus.d_source), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_a_ready", 64'(bus.a_ready), 64'd1);

        // Full write, byte-lane partial writes, read-back.
        txn(3'd0, 3'd3, 8'd2, 32'h2000, 8'hFF, 64'h11223344AABBCCDD, 0, rd);
        txn(3'd1, 3'd3, 8'd1, 32'h2000, 8'h0F, 64'h00000000FFFFFFFF, 0, rd);
        txn(3'd4, 3'd3, 8'd7, 32'h2000, 8'hFF, 64'h0, 0, rd);
        check("partial_readback", rd, 64'h11223344FFFFFFFF);
        txn(3'd0, 3'd3, 8'd3, 32'h4000, 8'hFF, 64'hAA55AA55AA55AA55, 0, rd);
        txn(3'd1, 3'd3, 8'd3, 32'h4000, 8'h55, 64'h00FFFF0000FFFF00, 0, rd);
        txn(3'd4, 3'd3, 8'd4, 32'h4000, 8'hFF, 64'h0, 0, rd);
        check("mask55_readback", rd, 64'hAAFFAA00AAFFAA00);

        // Denied: out of range, misaligned, bad opcode.
        txn(3'd4, 3'd3, 8'd5, 32'h8000, 8'hFF, 64'h0, 0, rd);
        txn(3'd4, 3'd3, 8'd5, 32'h1004, 8'hFF, 64'h0, 0, rd);
        txn(3'd2, 3'd3, 8'd5, 32'h2000, 8'hFF, 64'hDEADBEEFDEADBEEF, 0, rd);
        check("denied_count_3", 64'(denied_count), 64'd3);
        txn(3'd4, 3'd3, 8'd6, 32'h2000, 8'hFF, 64'h0, 0, rd);
        check("unchanged_2000", rd, 64'h11223344FFFFFFFF);

        // Back-pressure: d_ready held low for 4 cycles.
        txn(3'd4, 3'd3, 8'd9, 32'h4000, 8'hFF, 64'h0, 4, rd);

        // Pool of initialised words, then randomized traffic.
        for (int i = 0; i < 8; i++) begin
            txn(3'd0, 3'd3, 8'($urandom), 32'h3000 + 32'(i * 8), 8'hFF, {$urandom, $urandom}, 0,
                rd);
        end
        for (int i = 0; i < 60; i++) begin
            k = int'($urandom_range(9));
            addr = 32'h3000 + 32'($urandom_range(7) * 8);
            if (k < 7) begin
                op = (k < 3) ? 3'd4 : ((k < 5) ? 3'd0 : 3'd1);
                size = 3'($urandom_range(3));
                addr = addr + 32'($urandom_range(7) & ~((1 << size) - 1));
            end else begin
                op = 3'($urandom_range(7));
                size = 3'($urandom_range(7));
                addr = (k == 9) ? 32'h8000 + 32'($urandom_range(4095)) * 8
                                : addr + 32'($urandom_range(7));
            end
            txn(op, size, 8'($urandom), addr, 8'($urandom), {$urandom, $urandom},
                int'($urandom_range(2)), rd);
        end

        // Async reset in RESP of a Get aborts it; storage survives.
        @(negedge clk);
        bus.a_valid = 1'b1; bus.a_opcode = 3'd4; bus.a_size = 3'd3; bus.a_source = 8'd1;
        bus.a_address = 32'h2000; bus.a_mask = 8'hFF;
        @(posedge clk);
        #1;
        bus.a_valid = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_d_valid", 64'(bus.d_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_d_valid", 64'(bus.d_valid), 64'd0);
        check("async_rst_denied_count", 64'(denied_count), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_d_data", bus.d_data, 64'd0);
        check("async_rst_a_ready", 64'(bus.a_ready), 64'd0);
        dc_m = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_release_a_ready", 64'(bus.a_ready), 64'd1);
        txn(3'd4, 3'd3, 8'd7, 32'h2000, 8'hFF, 64'h0, 0, rd);
        check("mem_survives_rst", rd, 64'h11223344FFFFFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
